// File: rtl/mxint_cast_arbiter_pkg.sv
// Shared types and helpers for the MxInt cast arbiter.
// Round-robin pick function and width helpers for tags and counts.
package mxint_cast_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_REQ       = 32;
    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_TAG_DEPTH = 4;

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction

    localparam int TAG_W = tag_w(DEF_NUM_REQ);
    localparam int CNT_W = cnt_w(DEF_TAG_DEPTH);

    // First valid index at or after ptr, cyclic over n; ptr when none valid.
    function automatic int rr_next(
        input int                   ptr,
        input logic [MAX_REQ-1:0]   valid_vec,
        input int                   n
    );
        int idx;
        rr_next = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (valid_vec[idx[4:0]]) rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mxint_cast_arbiter_if.sv
// Requester-side and cast-side handshake bundle for the cast arbiter.
// master: producers/consumers and cast model; slave: the arbiter.
interface mxint_cast_arbiter_if
    import mxint_cast_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int MAN_WIDTH     = 8,
    parameter int EXP_WIDTH     = 8,
    parameter int OUT_MAN_WIDTH = 8,
    parameter int OUT_EXP_WIDTH = 8,
    parameter int BLOCK_SIZE    = 4
);
    logic signed [MAN_WIDTH-1:0]     mdata_in  [NUM_REQ][BLOCK_SIZE];
    logic [EXP_WIDTH-1:0]            edata_in  [NUM_REQ];
    logic [NUM_REQ-1:0]              data_in_valid;
    logic [NUM_REQ-1:0]              data_in_ready;

    logic signed [OUT_MAN_WIDTH-1:0] mdata_out [NUM_REQ][BLOCK_SIZE];
    logic [OUT_EXP_WIDTH-1:0]        edata_out [NUM_REQ];
    logic [NUM_REQ-1:0]              data_out_valid;
    logic [NUM_REQ-1:0]              data_out_ready;

    logic signed [MAN_WIDTH-1:0]     cast_mdata_in  [BLOCK_SIZE];
    logic [EXP_WIDTH-1:0]            cast_edata_in;
    logic                            cast_in_valid;
    logic                            cast_in_ready;

    logic signed [OUT_MAN_WIDTH-1:0] cast_mdata_out [BLOCK_SIZE];
    logic [OUT_EXP_WIDTH-1:0]        cast_edata_out;
    logic                            cast_out_valid;
    logic                            cast_out_ready;

    modport master (
        output mdata_in, edata_in, data_in_valid,
        input  data_in_ready,
        input  mdata_out, edata_out, data_out_valid,
        output data_out_ready,
        input  cast_mdata_in, cast_edata_in, cast_in_valid,
        output cast_in_ready,
        output cast_mdata_out, cast_edata_out, cast_out_valid,
        input  cast_out_ready
    );

    modport slave (
        input  mdata_in, edata_in, data_in_valid,
        output data_in_ready,
        output mdata_out, edata_out, data_out_valid,
        input  data_out_ready,
        output cast_mdata_in, cast_edata_in, cast_in_valid,
        input  cast_in_ready,
        input  cast_mdata_out, cast_edata_out, cast_out_valid,
        output cast_out_ready
    );
endinterface

// File: rtl/mxint_cast_arbiter_tag_fifo.sv
// Register-array tag FIFO recording the owner of each in-flight block.
// No bypass: a push is refused while full even if a pop happens.
module mxint_tag_fifo
    import mxint_cast_arb_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = DEF_TAG_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/mxint_cast_arbiter.sv
// Round-robin block arbiter sharing one mxint_cast between requesters.
// Optional MXINT_CAST_ARB_PERF_EN adds per-requester accepted-block counters.
module mxint_cast_arbiter
    import mxint_cast_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int MAN_WIDTH     = 8,
    parameter int EXP_WIDTH     = 8,
    parameter int OUT_MAN_WIDTH = 8,
    parameter int OUT_EXP_WIDTH = 8,
    parameter int BLOCK_SIZE    = 4,
    parameter int TAG_DEPTH     = DEF_TAG_DEPTH
) (
    input  logic clk,
    input  logic rst,
`ifdef MXINT_CAST_ARB_PERF_EN
    output logic [NUM_REQ-1:0][31:0] perf_blocks,
`endif
    mxint_cast_arbiter_if.slave io
);
    localparam int TAGW = tag_w(NUM_REQ);

    arb_state_e         lock_q, lock_d;
    logic [TAGW-1:0]    grant_q, grant_d;
    logic [TAGW-1:0]    rr_q, rr_d;
    logic [TAGW-1:0]    rr_grant, grant, head;
    logic [MAX_REQ-1:0] vld_ext;
    logic               any_vld, tag_full, tag_empty;
    logic               xfer, pop;

    assign vld_ext  = MAX_REQ'(io.data_in_valid);
    assign any_vld  = |io.data_in_valid;
    assign rr_grant = TAGW'(rr_next(int'(rr_q), vld_ext, NUM_REQ));
    assign grant    = (lock_q == ARB_LOCKED) ? grant_q : rr_grant;

    // Handshake outputs are forced low while reset is held.
    assign io.cast_in_valid = ~rst & io.data_in_valid[grant]
                            & any_vld & ~tag_full;
    assign xfer = io.cast_in_valid & io.cast_in_ready;

    always_comb begin
        io.data_in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            io.data_in_ready[i] = ~rst & (grant == TAGW'(i))
                                & io.cast_in_ready & ~tag_full;
        end
    end

    always_comb begin
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            io.cast_mdata_in[k] = MAN_WIDTH'(io.mdata_in[grant][k]);
        end
        io.cast_edata_in = EXP_WIDTH'(io.edata_in[grant]);
    end

    always_comb begin
        lock_d  = lock_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (xfer) begin
            lock_d = ARB_IDLE;
            rr_d   = (grant == TAGW'(NUM_REQ - 1)) ? '0 : grant + TAGW'(1);
        end else if (io.cast_in_valid) begin
            lock_d  = ARB_LOCKED;
            grant_d = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q  <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            lock_q  <= lock_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    mxint_tag_fifo #(
        .W     (TAGW),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer),
        .din   (grant),
        .pop   (pop),
        .dout  (head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Only the valid bits are steered; data fans out to every port.
    always_comb begin
        io.data_out_valid = '0;
        io.cast_out_ready = 1'b0;
        if (!tag_empty) begin
            io.data_out_valid[head] = io.cast_out_valid;
            io.cast_out_ready       = io.data_out_ready[head];
        end
    end

    assign pop = io.cast_out_valid & io.cast_out_ready;

    always_comb begin
        for (int p = 0; p < NUM_REQ; p++) begin
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                io.mdata_out[p][k] = OUT_MAN_WIDTH'(io.cast_mdata_out[k]);
            end
            io.edata_out[p] = OUT_EXP_WIDTH'(io.cast_edata_out);
        end
    end

`ifdef MXINT_CAST_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && grant == TAGW'(i)) perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end

    assign perf_blocks = perf_q;
`endif
endmodule

// File: tb/tb_mxint_cast_arbiter.sv
// Directed cycle-by-cycle vectors for mxint_cast_arbiter.
// The bench plays the requesters, consumers and the shared cast.
module tb_mxint_cast_arbiter;
    localparam int N  = 2;
    localparam int BS = 4;
    localparam int NV = 35;

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mxint_cast_arbiter_if #(
        .NUM_REQ(N), .MAN_WIDTH(8), .EXP_WIDTH(8),
        .OUT_MAN_WIDTH(8), .OUT_EXP_WIDTH(8), .BLOCK_SIZE(BS)
    ) bus ();

`ifdef MXINT_CAST_ARB_PERF_EN
    logic [N-1:0][31:0] perf;
`endif

    mxint_cast_arbiter #(
        .NUM_REQ(N), .MAN_WIDTH(8), .EXP_WIDTH(8),
        .OUT_MAN_WIDTH(8), .OUT_EXP_WIDTH(8),
        .BLOCK_SIZE(BS), .TAG_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
`ifdef MXINT_CAST_ARB_PERF_EN
        .perf_blocks (perf),
`endif
        .io  (bus)
    );

    typedef struct {
        logic       r;
        logic [1:0] vin;
        logic       cir;
        logic       cov;
        logic [1:0] dor;
        logic [1:0] dir;
        logic       civ;
        logic [1:0] dov;
        logic       cor;
        int         eg;
        logic       pchk;
        int         p0;
        int         p1;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, i, act, exp);
        end
    endtask

    initial begin
        int xf, pops;
        logic drained;
        nvec = 0;
        nmis = 0;
        rst  = 1'b1;
        bus.data_in_valid  = '0;
        bus.data_out_ready = '0;
        bus.cast_in_ready  = 1'b0;
        bus.cast_out_valid = 1'b0;
        bus.cast_edata_out = '0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < BS; k++) bus.mdata_in[r][k] = 8'(r * 16 + k - 5);
            bus.edata_in[r] = 8'(64 + r);
        end
        for (int k = 0; k < BS; k++) bus.cast_mdata_out[k] = '0;

        //        r vin   cir cov dor    dir   civ dov   cor eg pc p0 p1
        tbl = '{
            '{1, 2'b00, 1, 0, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b10, 1, 0, 2'b11, 2'b10, 1, 2'b00, 0, 1, 0, 0, 0},
            '{0, 2'b10, 1, 0, 2'b11, 2'b10, 1, 2'b00, 1, 1, 0, 0, 0},
            '{0, 2'b10, 1, 1, 2'b11, 2'b10, 1, 2'b10, 1, 1, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b11, 2'b01, 0, 2'b10, 1, 0, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b11, 2'b01, 0, 2'b10, 1, 0, 0, 0, 0},
            '{0, 2'b00, 0, 1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0},
            '{1, 2'b00, 1, 0, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b11, 1, 0, 2'b11, 2'b01, 1, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b11, 2'b10, 1, 2'b01, 1, 1, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b11, 2'b01, 1, 2'b10, 1, 0, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b11, 2'b10, 1, 2'b01, 1, 1, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b11, 2'b01, 1, 2'b10, 1, 0, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b11, 2'b10, 1, 2'b01, 1, 1, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b11, 2'b01, 1, 2'b10, 1, 0, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b11, 2'b10, 1, 2'b01, 1, 1, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b11, 2'b01, 0, 2'b10, 1, 0, 1, 4, 4},
            '{0, 2'b11, 0, 0, 2'b11, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b10, 0, 0, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b11, 0, 0, 2'b11, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b11, 1, 0, 2'b11, 2'b01, 1, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b11, 1, 0, 2'b11, 2'b10, 1, 2'b00, 1, 1, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b00, 2'b01, 1, 2'b01, 0, 0, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b00, 2'b10, 1, 2'b01, 0, 1, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b01, 2'b00, 0, 2'b01, 1, 0, 0, 0, 0},
            '{0, 2'b11, 1, 1, 2'b00, 2'b01, 1, 2'b10, 0, 0, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b01, 2'b00, 0, 2'b10, 0, 0, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 2'b10, 1, 0, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b11, 2'b10, 0, 2'b01, 1, 0, 0, 0, 0},
            '{1, 2'b11, 1, 1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0},
            '{0, 2'b00, 0, 1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 1, 0, 0},
            '{0, 2'b10, 1, 0, 2'b11, 2'b10, 1, 2'b00, 0, 1, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b11, 2'b01, 0, 2'b10, 1, 0, 0, 0, 0},
            '{0, 2'b00, 1, 1, 2'b11, 2'b01, 0, 2'b00, 0, 0, 0, 0, 0}
        };

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst                = tbl[i].r;
            bus.data_in_valid  = tbl[i].vin;
            bus.cast_in_ready  = tbl[i].cir;
            bus.cast_out_valid = tbl[i].cov;
            bus.data_out_ready = tbl[i].dor;
            for (int k = 0; k < BS; k++) bus.cast_mdata_out[k] = 8'(i * 4 + k);
            bus.cast_edata_out = 8'(i + 100);
            #1;
            nvec++;
            chk("in_ready", i, 32'(bus.data_in_ready), 32'(tbl[i].dir));
            chk("cast_in_valid", i, 32'(bus.cast_in_valid), 32'(tbl[i].civ));
            chk("out_valid", i, 32'(bus.data_out_valid), 32'(tbl[i].dov));
            chk("cast_out_ready", i, 32'(bus.cast_out_ready), 32'(tbl[i].cor));
            if (tbl[i].civ) begin
                chk("edata_mux", i, 32'(bus.cast_edata_in), 32'(64 + tbl[i].eg));
                for (int k = 0; k < BS; k++)
                    chk("mdata_mux", i, 32'($unsigned(bus.cast_mdata_in[k])),
                        32'($unsigned(8'(tbl[i].eg * 16 + k - 5))));
            end
            for (int p = 0; p < N; p++) begin
                chk("edata_out", i, 32'(bus.edata_out[p]), 32'(i + 100));
                for (int k = 0; k < BS; k++)
                    chk("mdata_out", i, 32'($unsigned(bus.mdata_out[p][k])),
                        32'($unsigned(8'(i * 4 + k))));
            end
`ifdef MXINT_CAST_ARB_PERF_EN
            if (tbl[i].pchk) begin
                chk("perf0", i, perf[0], 32'(tbl[i].p0));
                chk("perf1", i, perf[1], 32'(tbl[i].p1));
            end
`endif
        end

        // Back-to-back stream from requester 0: one block per cycle.
        xf   = 0;
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.data_in_valid  = 2'b01;
            bus.cast_in_ready  = 1'b1;
            bus.cast_out_valid = 1'b1;
            bus.data_out_ready = 2'b11;
            #1;
            xf   += int'(bus.data_in_ready[0]);
            pops += int'(bus.data_out_valid[0] & bus.cast_out_ready);
        end
        nvec++;
        chk("stream_xfers", 0, 32'(xf), 32'd6);
        nvec++;
        chk("stream_pops", 0, 32'(pops), 32'd5);

        drained = 1'b0;
        for (int c = 0; c < 5 && !drained; c++) begin
            @(negedge clk);
            bus.data_in_valid = 2'b00;
            #1;
            if (bus.data_out_valid == 2'b00 && !bus.cast_out_ready) drained = 1'b1;
        end
        nvec++;
        chk("drain", 0, 32'(drained), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/mxint_cast_arbiter.md
# mxint_cast_arbiter

Shares one `mxint_cast` instance between `NUM_REQ` MxInt producer streams. Whole blocks (one mantissa vector plus one shared exponent) are granted round-robin and driven into the cast input. A tag FIFO records which requester owns each in-flight block, and each cast result is routed back to the owning requester's output port. It sits between several layer outputs and a single shared cast datapath in the linear-layer MxInt pipeline.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2)
- `MAN_WIDTH`, 8: input mantissa width (cast IN_MAN_WIDTH)
- `EXP_WIDTH`, 8: input exponent width (cast IN_EXP_WIDTH)
- `OUT_MAN_WIDTH`, 8: cast output mantissa width
- `OUT_EXP_WIDTH`, 8: cast output exponent width
- `BLOCK_SIZE`, 4: mantissas per block
- `TAG_DEPTH`, 4: maximum in-flight blocks (power of 2, ≥2)
- `clk`  in  1  sole clock; everything is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mdata_in`  in  `[NUM_REQ][BLOCK_SIZE]` × MAN_WIDTH signed  requester mantissas
- `edata_in`  in  `[NUM_REQ]` × EXP_WIDTH  requester exponents
- `data_in_valid` / `data_in_ready`  in/out  NUM_REQ  per-requester input handshake
- `mdata_out`  out  `[NUM_REQ][BLOCK_SIZE]` × OUT_MAN_WIDTH signed  routed results
- `edata_out`  out  `[NUM_REQ]` × OUT_EXP_WIDTH  routed exponents
- `data_out_valid` / `data_out_ready`  out/in  NUM_REQ  per-requester output handshake
- `cast_mdata_in`, `cast_edata_in`, `cast_in_valid` out; `cast_in_ready` in: drive the cast input
- `cast_mdata_out`, `cast_edata_out`, `cast_out_valid` in; `cast_out_ready` out: cast output
- `perf_blocks`  out  `[NUM_REQ]` × 32  accepted-block counters (present only with `MXINT_CAST_ARB_PERF_EN`)

## Operation
- **State:** `grant_q` (index) and `lock_q` (1 bit).
  - **IDLE** (`lock_q`=0): `grant` is the first valid requester at or after `rr_ptr`, cyclic.
  - **LOCKED** (`lock_q`=1): `grant` = `grant_q`.
- **Lock entry:** IDLE → LOCKED when a grant is issued but the transfer does not complete. The grant is captured in `grant_q`.
- **Lock release:** LOCKED → IDLE on transfer. A granted valid block is never abandoned.
- **Cast input drive:** `cast_in_valid` = `data_in_valid[grant]` & any-valid & !tag_full. The cast data inputs are a combinational mux of `grant`.
- **Requester ready:** `data_in_ready[i]` = (i==grant) & `cast_in_ready` & !tag_full. All other ready bits are 0.
- **On transfer:**
  - Push `grant` into the tag FIFO.
  - Set `rr_ptr` ← grant+1 mod NUM_REQ.
- **Output routing:** When the tag FIFO is non-empty, with head tag `t`:
  - `data_out_valid[t]` = `cast_out_valid`; all other valid bits are 0.
  - `cast_out_ready` = `data_out_ready[t]`.
  - Pop on the `cast_out` handshake.
- **Empty tag FIFO:** `cast_out_ready`=0 and all `data_out_valid`=0.
- **Output data:** `mdata_out`/`edata_out` carry `cast_*_out` to all ports. Only the valid bits are steered.
- **Full:** tag_full = count==TAG_DEPTH, evaluated at cycle start. A pop in the same cycle does not allow a push; no bypass.
- **Simultaneous push and pop:** allowed when not full; count is unchanged.

## Timing
- **Input path:** purely combinational, zero added latency.
- **Cast latency:** the cast must have ≥1 cycle latency. A pushed tag becomes visible at the head on the next cycle.
- **Reset values:**
  - `rr_ptr`=0, `grant_q`=0, `lock_q`=0, tag FIFO empty.
  - All `data_in_ready`=0, `data_out_valid`=0, `cast_in_valid`=0, `cast_out_ready`=0.
  - `perf_blocks`=0.
- **Reset mid-operation:** in-flight tags are discarded. The cast instance must be reset by the same `rst`.
- **Throughput:** one block per cycle when the cast is always ready and the FIFO is not full.

## Configuration
- **`MXINT_CAST_ARB_PERF_EN` defined:** adds `perf_blocks`. Entry i increments by 1 on each accepted transfer from requester i and wraps at 2^32.
- **`MXINT_CAST_ARB_PERF_EN` undefined:** the port and counters are absent. The arbitration and routing behaviour is identical.

## Structure
- **Package `mxint_cast_arb_pkg`:** holds `TAG_W` = max(1, $clog2(NUM_REQ)) and `CNT_W` = $clog2(TAG_DEPTH)+1, with helper function `rr_next(ptr, valid_vec)`.
- **Sub-module `mxint_tag_fifo`:** register-array FIFO with push/pop and full/empty/count. Asynchronous reset, no bypass.

## Test plan
- **Single requester:** NUM_REQ=2, requester 1 only, 3 blocks, cast latency 2 → `data_out_valid[1]` three times in order; requester 0 sees no valid.
- **Fairness:** both requesters always valid, cast always ready → grant order 0,1,0,1; `perf_blocks`={4,4} after 8 blocks.
- **Lock hold:** req 0 granted, `cast_in_ready`=0 for 3 cycles while req 1 is also valid → `grant_q` stays 0; req 0 transfers first, then req 1.
- **Full FIFO:** TAG_DEPTH=4, `cast_out_ready` held low by `data_out_ready`=0, 4 blocks accepted → the 5th is refused (`data_in_ready` all 0). One pop in the same cycle as the 5th request → still refused; accepted the next cycle.
- **Output backpressure:** head tag 1, `data_out_ready[1]`=0 and `data_out_ready[0]`=1 → `cast_out_ready`=0, no pop; releasing port 1 → pop.
- **Reset mid-flight:** assert `rst` with 2 tags in flight → all valids 0 and the FIFO is empty immediately; traffic after reset routes correctly.
